// File: rtl/demo_slave_responder.sv
// Memory-backed bus slave: accepts one request at a time, waits LATENCY cycles,
// then commits the write or returns the read, mirroring the last write on LED.
module demo_slave_responder #(
   parameter int                    DATA_WIDTH           = 8,
   parameter int                    SLAVE_MEM_ADDR_WIDTH = 13,
   parameter int                    MEM_ADDR_WIDTH       = 5,
   parameter int                    LATENCY              = 2,
   parameter logic [DATA_WIDTH-1:0] OOR_FILL             = 8'hFF
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            s_valid,
   input  logic                            s_rw,
   input  logic [SLAVE_MEM_ADDR_WIDTH-1:0] s_addr,
   input  logic [DATA_WIDTH-1:0]           s_wdata,
   output logic                            s_ready,
   output logic                            s_done,
   output logic [DATA_WIDTH-1:0]           s_rdata,
   output logic [DATA_WIDTH-1:0]           LED,
   output logic [7:0]                      wr_count,
   output logic                            err
);

   localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                          state, state_nx;
   logic [3:0]                      cnt, cnt_nx;
   logic                            req_rw;
   logic [SLAVE_MEM_ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]           req_wdata;
   logic [DATA_WIDTH-1:0]           mem [MEM_DEPTH];

   logic                            op_rw;
   logic [SLAVE_MEM_ADDR_WIDTH-1:0] op_addr;
   logic [DATA_WIDTH-1:0]           op_wdata;
   logic                            in_range;
   logic [MEM_ADDR_WIDTH-1:0]       idx;
   logic                            commit;

   // With LATENCY=0 the commit happens on the accept edge, before the latch holds the request.
   assign op_rw    = (state == IDLE) ? s_rw    : req_rw;
   assign op_addr  = (state == IDLE) ? s_addr  : req_addr;
   assign op_wdata = (state == IDLE) ? s_wdata : req_wdata;
   assign in_range = (op_addr[SLAVE_MEM_ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0);
   assign idx      = op_addr[MEM_ADDR_WIDTH-1:0];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (s_valid) begin
               if (LATENCY == 0) begin
                  state_nx = RESP;
                  commit   = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               state_nx = RESP;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_rw    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         s_ready   <= 1'b1;
         s_done    <= 1'b0;
         s_rdata   <= '0;
         LED       <= '0;
         wr_count  <= 8'd0;
         err       <= 1'b0;
         // NOTE: the memory is a reset register file, so readback after reset is defined as zero.
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         s_ready <= (state_nx == IDLE);
         s_done  <= commit;
         if (state == IDLE && s_valid) begin
            req_rw    <= s_rw;
            req_addr  <= s_addr;
            req_wdata <= s_wdata;
         end
         if (commit) begin
            if (in_range) begin
               if (op_rw) begin
                  mem[idx] <= op_wdata;
                  LED      <= op_wdata;
                  wr_count <= wr_count + 8'd1;
               end else begin
                  s_rdata <= mem[idx];
               end
            end else begin
               err <= 1'b1;
               if (!op_rw) s_rdata <= OOR_FILL;
            end
         end
      end
   end

endmodule

// File: tb/tb_demo_slave_responder.sv
// Scoreboard bench: two responders (LATENCY=2 and LATENCY=0) driven by directed and
// random requests; a negedge monitor compares every completion against a queue model.
module tb_demo_slave_responder;

   localparam int SAW = 13;

   typedef struct {
      int         done_cyc;
      logic [7:0] x_rdata;
      logic [7:0] x_led;
      logic [7:0] x_wrc;
      logic       x_err;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;

   logic           rstn  [2];
   logic           valid [2];
   logic           rw    [2];
   logic [SAW-1:0] addr  [2];
   logic [7:0]     wdata [2];
   logic           ready [2];
   logic           done  [2];
   logic [7:0]     rdata [2];
   logic [7:0]     led   [2];
   logic [7:0]     wrc   [2];
   logic           err   [2];

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;
   int lat_of [2] = '{2, 0};

   logic [7:0] mmem    [2][32];
   logic [7:0] led_m   [2];
   logic [7:0] wrc_m   [2];
   logic       err_m   [2];
   logic [7:0] last_rd [2];
   exp_t       sbq     [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   demo_slave_responder #(.DATA_WIDTH(8), .SLAVE_MEM_ADDR_WIDTH(13), .MEM_ADDR_WIDTH(5),
                          .LATENCY(2), .OOR_FILL(8'hFF)) dut_l2 (
      .clk(clk), .rstn(rstn[0]), .s_valid(valid[0]), .s_rw(rw[0]), .s_addr(addr[0]),
      .s_wdata(wdata[0]), .s_ready(ready[0]), .s_done(done[0]), .s_rdata(rdata[0]),
      .LED(led[0]), .wr_count(wrc[0]), .err(err[0]));

   demo_slave_responder #(.DATA_WIDTH(8), .SLAVE_MEM_ADDR_WIDTH(13), .MEM_ADDR_WIDTH(5),
                          .LATENCY(0), .OOR_FILL(8'hFF)) dut_l0 (
      .clk(clk), .rstn(rstn[1]), .s_valid(valid[1]), .s_rw(rw[1]), .s_addr(addr[1]),
      .s_wdata(wdata[1]), .s_ready(ready[1]), .s_done(done[1]), .s_rdata(rdata[1]),
      .LED(led[1]), .wr_count(wrc[1]), .err(err[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model(input int sel);
      for (int i = 0; i < 32; i++) mmem[sel][i] = 8'h00;
      led_m[sel]   = 8'h00;
      wrc_m[sel]   = 8'h00;
      err_m[sel]   = 1'b0;
      last_rd[sel] = 8'h00;
   endtask

   // Behavioural view: a 32-entry byte array; anything at or above 32 is out of range.
   task automatic model_op(input int sel, input bit w, input int a, input logic [7:0] d,
                           output exp_t e);
      bit inr;
      inr = (a < 32);
      if (w) begin
         if (inr) begin
            mmem[sel][a[4:0]] = d;
            led_m[sel] = d;
            wrc_m[sel] = wrc_m[sel] + 8'd1;
         end else begin
            err_m[sel] = 1'b1;
         end
      end else begin
         last_rd[sel] = inr ? mmem[sel][a[4:0]] : 8'hFF;
         if (!inr) err_m[sel] = 1'b1;
      end
      e.done_cyc = 0;
      e.x_rdata  = last_rd[sel];
      e.x_led    = led_m[sel];
      e.x_wrc    = wrc_m[sel];
      e.x_err    = err_m[sel];
   endtask

   // Presents a request (valid stays high afterwards) and waits for its accept edge.
   task automatic issue(input int sel, input bit w, input int a, input logic [7:0] d,
                        output int acc);
      exp_t e;
      int   n;
      n = 0;
      acc = -1;
      valid[sel] = 1'b1;
      rw[sel]    = w;
      addr[sel]  = a[12:0];
      wdata[sel] = d;
      while (!ready[sel] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready[sel]) begin
         check($sformatf("accept_timeout[%0d]", sel), 32'(ready[sel]), 32'd1);
         return;
      end
      @(posedge clk); #1;
      acc = cyc;
      model_op(sel, w, a, d, e);
      e.done_cyc = cyc + lat_of[sel];
      sbq[sel].push_back(e);
   endtask

   task automatic drain(input int sel);
      int n;
      n = 0;
      valid[sel] = 1'b0;
      while (sbq[sel].size() > 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq[sel].size() > 0) begin
         check($sformatf("drain_timeout[%0d]", sel), 32'(sbq[sel].size()), 32'd0);
         sbq[sel].delete();
      end
      @(posedge clk); #1;
   endtask

   // Monitor: a completion must appear exactly in its expected cycle, nowhere else.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            if (sbq[i].size() > 0 && sbq[i][0].done_cyc == cyc) begin
               e = sbq[i].pop_front();
               check($sformatf("done[%0d]", i),  32'(done[i]),  32'd1);
               check($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(e.x_rdata));
               check($sformatf("led[%0d]", i),   32'(led[i]),   32'(e.x_led));
               check($sformatf("wrc[%0d]", i),   32'(wrc[i]),   32'(e.x_wrc));
               check($sformatf("err[%0d]", i),   32'(err[i]),   32'(e.x_err));
               check($sformatf("ready_resp[%0d]", i), 32'(ready[i]), 32'd0);
            end else begin
               check($sformatf("done_idle[%0d]", i), 32'(done[i]), 32'd0);
               check($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(sbq[i].size() == 0));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int a1, a2, t, a;
      bit w;
      for (int s = 0; s < 2; s++) begin
         rstn[s] = 1'b0; valid[s] = 1'b0; rw[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
         reset_model(s);
      end
      repeat (3) @(posedge clk);
      #1;
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      started = 1'b1;
      for (int s = 0; s < 2; s++) begin
         check("rst_ready", 32'(ready[s]), 32'd1);
         check("rst_done",  32'(done[s]),  32'd0);
         check("rst_rdata", 32'(rdata[s]), 32'd0);
         check("rst_led",   32'(led[s]),   32'd0);
         check("rst_wrc",   32'(wrc[s]),   32'd0);
         check("rst_err",   32'(err[s]),   32'd0);
      end

      // Write then read back, plus a never-written location.
      issue(0, 1'b1, 1, 8'hA5, t);
      drain(0);
      check("led_after_write", 32'(led[0]), 32'h A5);
      issue(0, 1'b0, 1, 8'h00, t);
      issue(0, 1'b0, 6, 8'h00, t);
      drain(0);

      // Back-to-back with s_valid held high.
      issue(0, 1'b1, 2, 8'h11, a1);
      issue(0, 1'b1, 3, 8'h22, a2);
      check("b2b_gap", 32'(a2 - a1), 32'd4);
      drain(0);
      check("led_b2b", 32'(led[0]), 32'h22);

      // Out-of-range write is dropped and flags err; the read returns the fill value.
      issue(0, 1'b1, 'h21, 8'h5A, t);
      issue(0, 1'b0, 'h21, 8'h00, t);
      drain(0);
      check("oor_err", 32'(err[0]), 32'd1);

      // Reset in the first busy cycle of a write drops it.
      issue(0, 1'b1, 4, 8'h77, t);
      rstn[0] = 1'b0;
      @(posedge clk); #1;
      sbq[0].delete();
      reset_model(0);
      rstn[0]  = 1'b1;
      valid[0] = 1'b0;
      check("midrst_ready", 32'(ready[0]), 32'd1);
      check("midrst_done",  32'(done[0]),  32'd0);
      check("midrst_led",   32'(led[0]),   32'd0);
      check("midrst_wrc",   32'(wrc[0]),   32'd0);
      check("midrst_err",   32'(err[0]),   32'd0);
      issue(0, 1'b0, 4, 8'h00, t);
      drain(0);

      // Random traffic on the LATENCY=2 responder, mixing held valid and idle gaps.
      for (int k = 0; k < 150; k++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191))
                                         : int'($urandom_range(0, 31));
         issue(0, w, a, 8'($urandom), t);
         if ($urandom_range(0, 2) == 0) drain(0);
      end
      drain(0);

      // LATENCY=0: 256 back-to-back writes wrap the counter to zero.
      for (int k = 0; k < 256; k++) issue(1, 1'b1, int'($urandom_range(0, 31)), 8'($urandom), t);
      drain(1);
      check("wrap_wrc", 32'(wrc[1]), 32'd0);
      for (int k = 0; k < 24; k++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 5) == 0) ? int'($urandom_range(32, 8191))
                                         : int'($urandom_range(0, 31));
         issue(1, w, a, 8'($urandom), t);
      end
      drain(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demo_slave_responder.md
# demo_slave_responder

Memory-backed demo responder that sits at the slave end of the system bus, behind the slave port adapter. It accepts single read/write requests, applies a programmable response latency, then commits writes to or returns reads from a small register-file memory. The last written byte drives the board LEDs. It is the counterpart of the button-driven master demo and lets a board test the full write-then-read-back loop against a known slave.

## Interface
Parameters:
- DATA_WIDTH, 8: data word width.
- SLAVE_MEM_ADDR_WIDTH, 13: width of the bus-side slave address.
- MEM_ADDR_WIDTH, 5: local memory index width; depth = 2^MEM_ADDR_WIDTH words.
- LATENCY, 2: wait cycles between accept and response, legal range 0..15.
- OOR_FILL, 8'hFF: read data returned for out-of-range addresses.

Ports (`rstn` synchronous, active-low; clock `clk`):
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- s_valid  in  1  request present; sampled only while s_ready=1.
- s_rw  in  1  1 = write, 0 = read.
- s_addr  in  SLAVE_MEM_ADDR_WIDTH  request address.
- s_wdata  in  DATA_WIDTH  write data.
- s_ready  out  1  high only in IDLE; reset 1.
- s_done  out  1  one-cycle completion pulse for both reads and writes; reset 0.
- s_rdata  out  DATA_WIDTH  read data, valid while s_done=1 and the op is a read; holds its value otherwise; reset 0.
- LED  out  DATA_WIDTH  last successfully committed write data; reset 0.
- wr_count  out  8  committed-write counter, wraps 255→0; reset 0.
- err  out  1  sticky out-of-range flag, cleared only by reset; reset 0.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: s_ready=1. When s_valid=1, latch s_rw, s_addr and s_wdata.
  - LATENCY>0: go to BUSY with cnt=LATENCY-1.
  - LATENCY=0: go directly to RESP.
- BUSY: s_ready=0. Decrement cnt. When cnt==0, go to RESP.
- On the edge entering RESP, with the latched request:
  - In range (s_addr[SLAVE_MEM_ADDR_WIDTH-1:MEM_ADDR_WIDTH]==0), write: mem[s_addr[MEM_ADDR_WIDTH-1:0]] ← wdata, LED ← wdata, wr_count+1.
  - In range, read: s_rdata ← mem[idx].
  - Out of range, write: dropped; LED and wr_count unchanged; err ← 1.
  - Out of range, read: s_rdata ← OOR_FILL; err ← 1.
- RESP: s_done=1 and s_ready=0 for exactly one cycle, then IDLE.
- Requests are never queued. s_valid during BUSY or RESP is ignored. A master holding s_valid high gets a new accept on the first IDLE cycle.
- Memory is cleared to 0 on reset.
- A read of a location in the same transaction as its write is impossible, because there is only one op in flight.
- Reset mid-operation: return to IDLE and drop the in-flight op (no memory write). s_done=0, s_ready=1, LED=0, wr_count=0, err=0, memory cleared.

## Timing
- Cycle 0: accept (s_valid=1 and s_ready=1).
- Cycles 1..LATENCY: BUSY.
- Cycle LATENCY+1: RESP (s_done=1, s_rdata valid, memory/LED/wr_count updated).
- Cycle LATENCY+2: IDLE, s_ready=1.
- Throughput: one op per LATENCY+2 cycles. With LATENCY=0, s_done is in cycle 1 and the next accept is possible in cycle 2.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Test plan
- Write: LATENCY=2, write s_addr=0x0001, s_wdata=0xA5 in cycle 0. Required: s_ready=0 in cycles 1–3; s_done=1 in cycle 3 only; LED=0xA5 and wr_count=1 from cycle 3; s_ready=1 in cycle 4.
- Read-back: after the write above, read s_addr=0x0001. Required: s_done=1 with s_rdata=0xA5 three cycles after accept. A read of unwritten 0x0006 returns 0x00.
- Back-to-back: hold s_valid=1 with writes 0x11→addr 2, then 0x22→addr 3. Required: second accept exactly 4 cycles after the first (LATENCY=2); LED ends at 0x22; wr_count=2.
- Out of range: write 0x5A to 0x0021, then read 0x0021 (MEM_ADDR_WIDTH=5). Required: LED and wr_count unchanged; err=1 after the write's s_done; read returns 0xFF.
- Reset mid-op: assert rstn=0 in cycle 1 of a write (0x77→addr 4). Required: next cycle s_ready=1, s_done=0; a read of addr 4 returns 0x00.
- LATENCY=0 plus wrap: 256 writes. Required: s_done in cycle 1 of each op; wr_count reads 0 after the 256th write.
